// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback scheduler slice.
package rf_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_DW  = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Writeback / issue / query bundle between requesters, decode and rf_wb_scheduler.
// Forwarding signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_scheduler_if
  import rf_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = REG_DW,
  parameter int unsigned AW     = REG_AW
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AW-1:0]     req_waddr;
  logic [NREQ*DATA_W-1:0] req_wdata;

  logic                   rf_we;
  logic [AW-1:0]          rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;

  logic                   issue_valid;
  logic [AW-1:0]          issue_waddr;
  logic                   issue_ready;

  logic [AW-1:0]          q_addr1;
  logic [AW-1:0]          q_addr2;
  logic                   q_busy1;
  logic                   q_busy2;
`ifdef RF_WB_FWD_EN
  logic                   q_fwd1;
  logic                   q_fwd2;
  logic [DATA_W-1:0]      q_fdata1;
  logic [DATA_W-1:0]      q_fdata2;
`endif

  modport master (
    output req_valid, req_waddr, req_wdata,
    input  req_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output issue_valid, issue_waddr,
    input  issue_ready,
    output q_addr1, q_addr2,
`ifdef RF_WB_FWD_EN
    input  q_fwd1, q_fwd2, q_fdata1, q_fdata2,
`endif
    input  q_busy1, q_busy2
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata,
    output req_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  issue_valid, issue_waddr,
    output issue_ready,
    input  q_addr1, q_addr2,
`ifdef RF_WB_FWD_EN
    output q_fwd1, q_fwd2, q_fdata1, q_fdata2,
`endif
    output q_busy1, q_busy2
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr, first request wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the regfile write port among NREQ writeback sources and keeps a busy scoreboard.
// Optional same-cycle query bypass is enabled with RF_WB_FWD_EN.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = REG_DW,
  parameter int unsigned AW     = REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  rf_wb_scheduler_if.slave  bus
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDXW-1:0]   arb_idx;
  logic [NREQ-1:0]   gnt_ok;
  logic              gnt_any;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_int;
  logic              issue_ready_int;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grants are masked while reset is high so nothing transfers that cycle.
  always_comb begin
    gnt_ok   = reset ? '0 : arb_gnt;
    gnt_any  = |gnt_ok;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_ok[i]) begin
        sel_addr = bus.req_waddr[i*AW +: AW];
        sel_data = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
    we_int          = gnt_any && (sel_addr != ZERO_ADDR);
    issue_ready_int = !busy_q[bus.issue_waddr] || (bus.issue_waddr == ZERO_ADDR);
  end

  // Set is applied after clear so a same-cycle issue to the written register stays busy.
  always_comb begin
    busy_d   = busy_q;
    rr_ptr_d = gnt_any ? arb_idx : rr_ptr_q;
    if (we_int) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (bus.issue_valid && issue_ready_int && (bus.issue_waddr != ZERO_ADDR)) begin
      busy_d[bus.issue_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= '0;
      rr_ptr_q <= IDXW'(NREQ - 1);
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_ready   = gnt_ok;
  assign bus.rf_we       = we_int;
  assign bus.rf_waddr    = sel_addr;
  assign bus.rf_wdata    = sel_data;
  assign bus.issue_ready = issue_ready_int;

`ifdef RF_WB_FWD_EN
  logic hit1, hit2;

  always_comb begin
    hit1 = we_int && (sel_addr == bus.q_addr1);
    hit2 = we_int && (sel_addr == bus.q_addr2);
  end

  assign bus.q_fwd1   = hit1;
  assign bus.q_fwd2   = hit2;
  assign bus.q_fdata1 = hit1 ? sel_data : '0;
  assign bus.q_fdata2 = hit2 ? sel_data : '0;
  assign bus.q_busy1  = busy_q[bus.q_addr1] && (bus.q_addr1 != ZERO_ADDR) && !hit1;
  assign bus.q_busy2  = busy_q[bus.q_addr2] && (bus.q_addr2 != ZERO_ADDR) && !hit2;
`else
  assign bus.q_busy1  = busy_q[bus.q_addr1] && (bus.q_addr1 != ZERO_ADDR);
  assign bus.q_busy2  = busy_q[bus.q_addr2] && (bus.q_addr2 != ZERO_ADDR);
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: expected grants queued at drive time, popped on req_ready.
module tb_rf_wb_scheduler;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  typedef struct {
    int unsigned idx;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  rf_wb_scheduler_if #(.NREQ(NREQ), .DATA_W(DW), .AW(AW)) bus ();

  rf_wb_scheduler #(.NREQ(NREQ), .DATA_W(DW), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic set_req(input int unsigned i, input logic [4:0] a, input logic [31:0] d);
    bus.req_waddr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic expect_gnt(input int unsigned i, input bit we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.idx = i; e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Output monitor: every grant must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (bus.req_ready != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", 64'(bus.req_ready), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("gnt_onehot", 64'($countones(bus.req_ready)), 64'd1);
        chk("gnt_idx", 64'(bus.req_ready), 64'(3'b001 << e.idx));
        chk("rf_we", 64'(bus.rf_we), 64'(e.we));
        if (e.we) begin
          chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.addr));
          chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
        end
      end
    end else begin
      chk("we_idle", 64'(bus.rf_we), 64'd0);
    end
  end

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_waddr   = '0;
    bus.req_wdata   = '0;
    bus.issue_valid = 1'b0;
    bus.issue_waddr = '0;
    bus.q_addr1     = '0;
    bus.q_addr2     = '0;

    // Requests held during reset must not be granted.
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    bus.req_valid = 3'b111;
    at_pos; at_pos;
    at_neg;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);

    at_pos;
    reset = 1'b0; bus.req_valid = '0; bus.q_addr1 = 5'd5; bus.issue_waddr = 5'd5;
    at_neg;
    chk("rst_busy5", 64'(bus.q_busy1), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);

    // Issue x5, then ALU writes it back.
    at_pos;
    bus.issue_valid = 1'b1;
    at_neg;
    chk("issue5_ready", 64'(bus.issue_ready), 64'd1);
    at_pos;
    bus.issue_valid = 1'b0;
    at_neg;
    chk("busy5_set", 64'(bus.q_busy1), 64'd1);
    chk("issue5_waw", 64'(bus.issue_ready), 64'd0);
    at_pos;
    set_req(0, 5'd5, 32'h1234); bus.req_valid = 3'b001;
    expect_gnt(0, 1'b1, 5'd5, 32'h1234);
    at_neg;
`ifdef RF_WB_FWD_EN
    chk("fwd1_hit", 64'(bus.q_fwd1), 64'd1);
    chk("fdata1", 64'(bus.q_fdata1), 64'h1234);
    chk("busy5_bypass", 64'(bus.q_busy1), 64'd0);
`else
    chk("busy5_during_wb", 64'(bus.q_busy1), 64'd1);
`endif
    at_pos;
    bus.req_valid = '0;
    at_neg;
    chk("busy5_clear", 64'(bus.q_busy1), 64'd0);

    // Mid-stream reset clears busy and suppresses that cycle's grant.
    at_pos;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd6;
    at_pos;
    bus.issue_valid = 1'b0; bus.q_addr1 = 5'd6;
    at_neg;
    chk("busy6_set", 64'(bus.q_busy1), 64'd1);
    at_pos;
    reset = 1'b1; set_req(0, 5'd6, 32'h66); bus.req_valid = 3'b001;
    at_neg;
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    at_pos;
    reset = 1'b0; bus.req_valid = '0;
    at_neg;
    chk("midrst_busy6", 64'(bus.q_busy1), 64'd0);

    // All three valid for six cycles: strict rotation from requester 0.
    at_pos;
    set_req(0, 5'd1, 32'h101); set_req(1, 5'd2, 32'h202); set_req(2, 5'd3, 32'h303);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      int unsigned r;
      r = c % 3;
      expect_gnt(r, 1'b1, 5'(r + 1), 32'((r + 1) * 32'h101));
    end
    repeat (6) at_pos;
    bus.req_valid = '0;

    // WAW on x7 until LSU writes it back.
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
    at_neg;
    chk("issue7_first", 64'(bus.issue_ready), 64'd1);
    at_pos;
    at_neg;
    chk("issue7_second", 64'(bus.issue_ready), 64'd0);
    at_pos;
    bus.issue_valid = 1'b0;
    set_req(1, 5'd7, 32'h77); bus.req_valid = 3'b010;
    expect_gnt(1, 1'b1, 5'd7, 32'h77);
    at_neg;
    chk("issue7_wb_cycle", 64'(bus.issue_ready), 64'd0);
    at_pos;
    bus.req_valid = '0;
    at_neg;
    chk("issue7_after_wb", 64'(bus.issue_ready), 64'd1);

    // Same-cycle write and issue of x9: set wins.
    at_pos;
    set_req(2, 5'd9, 32'h99); bus.req_valid = 3'b100;
    expect_gnt(2, 1'b1, 5'd9, 32'h99);
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd9; bus.q_addr1 = 5'd9;
    at_neg;
    chk("issue9_ready", 64'(bus.issue_ready), 64'd1);
    at_pos;
    bus.req_valid = '0; bus.issue_valid = 1'b0;
    at_neg;
    chk("set_wins_busy9", 64'(bus.q_busy1), 64'd1);
    at_pos;
    set_req(0, 5'd9, 32'h999); bus.req_valid = 3'b001;
    expect_gnt(0, 1'b1, 5'd9, 32'h999);
    at_pos;
    bus.req_valid = '0;
    at_neg;
    chk("busy9_clear", 64'(bus.q_busy1), 64'd0);

    // Write to x0: completes without rf_we, leaves other busy bits alone.
    at_pos;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd12;
    at_pos;
    bus.issue_valid = 1'b0;
    set_req(1, 5'd0, 32'hDEAD); bus.req_valid = 3'b010;
    expect_gnt(1, 1'b0, 5'd0, 32'hDEAD);
    bus.q_addr1 = 5'd0; bus.q_addr2 = 5'd12;
    at_neg;
    chk("x0_qbusy", 64'(bus.q_busy1), 64'd0);
    at_pos;
    bus.req_valid = '0;
    at_neg;
    chk("x12_unchanged", 64'(bus.q_busy2), 64'd1);
    at_pos;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd0;
    at_neg;
    chk("issue_x0_ready", 64'(bus.issue_ready), 64'd1);
    at_pos;
    bus.issue_valid = 1'b0;
    at_neg;
    chk("busy0_never", 64'(bus.q_busy1), 64'd0);

    // MDU writes x4 while decode queries it on port 2.
    at_pos;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd4;
    at_pos;
    bus.issue_valid = 1'b0; bus.q_addr2 = 5'd4;
    set_req(2, 5'd4, 32'hCAFE); bus.req_valid = 3'b100;
    expect_gnt(2, 1'b1, 5'd4, 32'hCAFE);
    at_neg;
`ifdef RF_WB_FWD_EN
    chk("fwd2_hit", 64'(bus.q_fwd2), 64'd1);
    chk("fdata2", 64'(bus.q_fdata2), 64'hCAFE);
    chk("busy4_bypass", 64'(bus.q_busy2), 64'd0);
    chk("fwd1_miss", 64'(bus.q_fwd1), 64'd0);
`else
    chk("busy4_during_wb", 64'(bus.q_busy2), 64'd1);
`endif
    at_pos;
    bus.req_valid = '0;
    at_neg;
    chk("busy4_clear", 64'(bus.q_busy2), 64'd0);

    at_pos;
    at_neg;
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
